// File: rtl/gnpu_cop_frontend.sv
// Coprocessor request front end for the GNPU tensor backend.
// Accepts CPU requests into a 2-deep FIFO, decodes one instruction at a time,
// dispatches legal ones to the backend, waits for completion and returns a
// tagged status word to the CPU in request order.
//
// Handshakes: every channel (request, dispatch, response) transfers on a rising
// edge where its valid and ready are both high; a valid, once raised, holds its
// payload stable and stays high until that transfer happens.
module gnpu_cop_frontend #(
    parameter int INST_W = 32,
    parameter int REG_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_tpu_req_vld_i,
    output logic              cpu_tpu_req_rdy_o,
    input  logic [INST_W-1:0] cpu_tpu_req_insn_i,
    input  logic [REG_W-1:0]  cpu_tpu_req_rs1_data_i,
    input  logic [REG_W-1:0]  cpu_tpu_req_rs2_data_i,
    input  logic [REG_W-1:0]  cpu_tpu_req_rs3_data_i,
    output logic              cpu_tpu_resp_vld_o,
    input  logic              cpu_tpu_resp_rdy_i,
    output logic [REG_W-1:0]  cpu_tpu_resp_data_o,
    output logic              disp_vld_o,
    input  logic              disp_rdy_i,
    output logic [1:0]        disp_op_o,
    output logic [REG_W-1:0]  disp_rs1_o,
    output logic [REG_W-1:0]  disp_rs2_o,
    output logic [REG_W-1:0]  disp_rs3_o,
    input  logic              done_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DISP = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [6:0] COP_OPCODE = 7'b0101011;

    state_t state;
    state_t state_nxt;

    // Request FIFO storage and bookkeeping
    logic [INST_W-1:0] fifo_insn [2];
    logic [REG_W-1:0]  fifo_rs1  [2];
    logic [REG_W-1:0]  fifo_rs2  [2];
    logic [REG_W-1:0]  fifo_rs3  [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              rdy_en;
    logic              push;
    logic              pop;

    // Head decode
    logic [INST_W-1:0] head_insn;
    logic [2:0]        head_funct3;
    logic              head_legal;
    logic [1:0]        head_op;

    // Latched in-flight instruction
    logic [1:0]        op_q;
    logic [REG_W-1:0]  rs1_q;
    logic [REG_W-1:0]  rs2_q;
    logic [REG_W-1:0]  rs3_q;
    logic [2:0]        funct3_q;
    logic              illegal_q;
    logic [7:0]        tag_q;
    logic              resp_fire;

    // Ready is held low through reset and rises one cycle after reset releases;
    // no pass-through when full, so a pop never reopens ready in the same cycle.
    assign cpu_tpu_req_rdy_o = rdy_en && (count != 2'd2);
    assign push              = cpu_tpu_req_vld_i && cpu_tpu_req_rdy_o;
    assign resp_fire         = cpu_tpu_resp_vld_o && cpu_tpu_resp_rdy_i;

    assign head_insn   = fifo_insn[rd_ptr];
    assign head_funct3 = head_insn[14:12];

    // Decode the FIFO head into a backend opcode and a legality flag
    always_comb begin
        head_legal = 1'b0;
        head_op    = 2'd0;
        if (head_insn[6:0] == COP_OPCODE) begin
            case (head_funct3)
                3'b001:  begin head_legal = 1'b1; head_op = 2'd0; end
                3'b100:  begin head_legal = 1'b1; head_op = 2'd1; end
                3'b010:  begin head_legal = 1'b1; head_op = 2'd2; end
                3'b011:  begin head_legal = 1'b1; head_op = 2'd3; end
                default: begin head_legal = 1'b0; head_op = 2'd0; end
            endcase
        end
    end

    // FIFO pointers, occupancy and the post-reset ready enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO payload; contents are meaningless while count says the slot is empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_insn[wr_ptr] <= cpu_tpu_req_insn_i;
            fifo_rs1[wr_ptr]  <= cpu_tpu_req_rs1_data_i;
            fifo_rs2[wr_ptr]  <= cpu_tpu_req_rs2_data_i;
            fifo_rs3[wr_ptr]  <= cpu_tpu_req_rs3_data_i;
        end
    end

    // Latch the popped instruction and advance the tag on each response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= 2'd0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rs3_q     <= '0;
            funct3_q  <= 3'd0;
            illegal_q <= 1'b0;
            tag_q     <= 8'd0;
        end else begin
            if (pop) begin
                op_q      <= head_op;
                rs1_q     <= fifo_rs1[rd_ptr];
                rs2_q     <= fifo_rs2[rd_ptr];
                rs3_q     <= fifo_rs3[rd_ptr];
                funct3_q  <= head_funct3;
                illegal_q <= !head_legal;
            end
            if (resp_fire) tag_q <= tag_q + 8'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state, FIFO pop and channel valids; done_i only matters in WAIT
    always_comb begin
        state_nxt          = state;
        pop                = 1'b0;
        disp_vld_o         = 1'b0;
        cpu_tpu_resp_vld_o = 1'b0;
        case (state)
            IDLE: begin
                if (count != 2'd0) begin
                    pop       = 1'b1;
                    state_nxt = head_legal ? DISP : RESP;
                end
            end
            DISP: begin
                disp_vld_o = 1'b1;
                if (disp_rdy_i) state_nxt = WAIT;
            end
            WAIT: begin
                if (done_i) state_nxt = RESP;
            end
            RESP: begin
                cpu_tpu_resp_vld_o = 1'b1;
                if (cpu_tpu_resp_rdy_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign disp_op_o  = op_q;
    assign disp_rs1_o = rs1_q;
    assign disp_rs2_o = rs2_q;
    assign disp_rs3_o = rs3_q;

    // Response word is only driven while it is being offered
    assign cpu_tpu_resp_data_o = cpu_tpu_resp_vld_o
        ? {{(REG_W-16){1'b0}}, tag_q, 3'b000, funct3_q, 1'b0, illegal_q}
        : '0;

endmodule

// File: tb/tb_gnpu_cop_frontend.sv
// Bench for gnpu_cop_frontend: table of instructions with expected decode,
// scoreboard queues for dispatch and response, and hand-written sequences for
// stalls, spurious completions, tag wrap and reset mid-operation.
module tb_gnpu_cop_frontend;

  localparam int INST_W = 32;
  localparam int REG_W  = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              req_vld;
  logic              req_rdy;
  logic [INST_W-1:0] req_insn;
  logic [REG_W-1:0]  req_rs1, req_rs2, req_rs3;
  logic              resp_vld;
  logic              resp_rdy;
  logic [REG_W-1:0]  resp_data;
  logic              disp_vld;
  logic              disp_rdy;
  logic [1:0]        disp_op;
  logic [REG_W-1:0]  disp_rs1, disp_rs2, disp_rs3;
  logic              done;
  logic              done_auto;
  logic              done_man;

  assign done = done_auto | done_man;

  gnpu_cop_frontend #(.INST_W(INST_W), .REG_W(REG_W)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .cpu_tpu_req_vld_i      (req_vld),
    .cpu_tpu_req_rdy_o      (req_rdy),
    .cpu_tpu_req_insn_i     (req_insn),
    .cpu_tpu_req_rs1_data_i (req_rs1),
    .cpu_tpu_req_rs2_data_i (req_rs2),
    .cpu_tpu_req_rs3_data_i (req_rs3),
    .cpu_tpu_resp_vld_o     (resp_vld),
    .cpu_tpu_resp_rdy_i     (resp_rdy),
    .cpu_tpu_resp_data_o    (resp_data),
    .disp_vld_o             (disp_vld),
    .disp_rdy_i             (disp_rdy),
    .disp_op_o              (disp_op),
    .disp_rs1_o             (disp_rs1),
    .disp_rs2_o             (disp_rs2),
    .disp_rs3_o             (disp_rs3),
    .done_i                 (done)
  );

  // ---------------- backend model: done a programmable delay after dispatch ----------------
  logic [3:0] be_lat;
  logic [3:0] be_cnt;
  logic       be_busy;

  always @(posedge clk) begin
    done_auto <= 1'b0;
    if (!rst_n) begin
      be_busy <= 1'b0;
      be_cnt  <= 4'd0;
    end else if (be_busy) begin
      if (be_cnt == 4'd0) begin
        done_auto <= 1'b1;
        be_busy   <= 1'b0;
      end else begin
        be_cnt <= be_cnt - 4'd1;
      end
    end else if (disp_vld && disp_rdy) begin
      be_busy <= 1'b1;
      be_cnt  <= be_lat - 4'd1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [193:0] exp_disp_q[$];
  logic [63:0]  exp_q[$];
  logic [7:0]   tag_m;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshakes are observed on the falling edge; inputs only change just after
  // a rising edge, so a vld&&rdy seen here transfers on the next rising edge.
  always @(negedge clk) begin : monitor
    logic [193:0] e;
    logic [63:0]  r;
    if (rst_n === 1'b1) begin
      if (disp_vld && disp_rdy) begin
        if (exp_disp_q.size() == 0) begin
          chk("disp_unexpected", 1, 0);
        end else begin
          e = exp_disp_q.pop_front();
          chk("disp_op",  disp_op,  e[193:192]);
          chk("disp_rs1", disp_rs1, e[191:128]);
          chk("disp_rs2", disp_rs2, e[127:64]);
          chk("disp_rs3", disp_rs3, e[63:0]);
        end
      end
      if (resp_vld && resp_rdy) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("resp_data", resp_data, r);
        end
      end
    end
  end

  // ---------------- driver tasks (all start and end 1 ns after a rising edge) ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] insn, input logic [63:0] r1, input logic [63:0] r2,
                          input logic [63:0] r3, input logic legal, input logic [1:0] op,
                          input logic [7:0] lo);
    bit ok;
    ok       = 1'b0;
    req_vld  = 1'b1;
    req_insn = insn;
    req_rs1  = r1;
    req_rs2  = r2;
    req_rs3  = r3;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("req_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    if (ok) begin
      if (legal) exp_disp_q.push_back({op, r1, r2, r3});
      exp_q.push_back({48'd0, tag_m, lo});
      tag_m = tag_m + 8'd1;
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return disp_vld == 1'b1;
      1:       return resp_vld == 1'b1;
      2:       return req_rdy == 1'b1;
      default: return (exp_q.size() == 0) && (exp_disp_q.size() == 0) && !resp_vld;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      if (cond(sel)) return;
      step(1);
    end
    if (!cond(sel)) chk(name, 0, 1);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [31:0] insn;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] rs3;
    logic        legal;
    logic [1:0]  op;
    logic [7:0]  resp_lo;
  } vec_t;

  vec_t       vecs[9];
  logic [2:0] f3s[4];
  logic [7:0] tag_a;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000102B, 64'h11,               64'h0,              64'h0,              1'b1, 2'd0, 8'h04};
    vecs[1] = '{32'h0000402B, 64'h1111_2222_3333_4444, 64'h55,          64'h66,             1'b1, 2'd1, 8'h10};
    vecs[2] = '{32'h0000202B, 64'h21,               64'h22,             64'h23,             1'b1, 2'd2, 8'h08};
    vecs[3] = '{32'h0000302B, 64'h31,               64'h32,             64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'd3, 8'h0C};
    vecs[4] = '{32'h0000502B, 64'h41,               64'h42,             64'h43,             1'b0, 2'd0, 8'h15};
    vecs[5] = '{32'h0000102A, 64'h51,               64'h52,             64'h53,             1'b0, 2'd0, 8'h05};
    vecs[6] = '{32'h0000002B, 64'h61,               64'h62,             64'h63,             1'b0, 2'd0, 8'h01};
    vecs[7] = '{32'hFFFF702B, 64'h71,               64'h72,             64'h73,             1'b0, 2'd0, 8'h1D};
    vecs[8] = '{32'hABCD302B, 64'h81,               64'h82,             64'h83,             1'b1, 2'd3, 8'h0C};
    f3s[0] = 3'b001;
    f3s[1] = 3'b100;
    f3s[2] = 3'b010;
    f3s[3] = 3'b011;

    rst_n    = 1'b0;
    req_vld  = 1'b0;
    req_insn = '0;
    req_rs1  = '0;
    req_rs2  = '0;
    req_rs3  = '0;
    resp_rdy = 1'b1;
    disp_rdy = 1'b1;
    done_man = 1'b0;
    be_lat   = 4'd3;
    tag_m    = 8'd0;

    // ---- reset state ----
    step(3);
    chk("rst_req_rdy",   req_rdy,   0);
    chk("rst_disp_vld",  disp_vld,  0);
    chk("rst_resp_vld",  resp_vld,  0);
    chk("rst_disp_op",   disp_op,   0);
    chk("rst_disp_rs1",  disp_rs1,  0);
    chk("rst_resp_data", resp_data, 0);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", req_rdy, 0);
    step(1);
    chk("rdy_after_reset", req_rdy, 1);

    // ---- table: all vectors back to back, full throughput ----
    for (int v = 0; v < 9; v++)
      send_req(vecs[v].insn, vecs[v].rs1, vecs[v].rs2, vecs[v].rs3,
               vecs[v].legal, vecs[v].op, vecs[v].resp_lo);
    wait_for(3, 300, "table_drain_timeout");

    // ---- latency: illegal request responds two cycles after acceptance ----
    send_req(32'h0000502B, 64'h1, 64'h2, 64'h3, 1'b0, 2'd0, 8'h15);
    chk("ill_resp_not_early", resp_vld, 0);
    step(1);
    chk("ill_resp_lat",   resp_vld,       1);
    chk("ill_status",     resp_data[1:0], 2'd1);
    chk("ill_funct3",     resp_data[4:2], 3'b101);
    chk("ill_no_disp",    disp_vld,       0);
    wait_for(3, 50, "ill_drain_timeout");

    // ---- latency: legal dispatch not before two cycles ----
    send_req(32'h0000402B, 64'h9, 64'h8, 64'h7, 1'b1, 2'd1, 8'h10);
    chk("disp_not_early", disp_vld, 0);
    wait_for(0, 5, "disp_lat_timeout");
    wait_for(3, 50, "lat_drain_timeout");

    // ---- stalls: dispatch held 5 cycles, response held 4 cycles, FIFO full ----
    disp_rdy = 1'b0;
    resp_rdy = 1'b0;
    be_lat   = 4'd3;
    tag_a    = tag_m;
    send_req(32'h0000202B, 64'hA1, 64'hA2, 64'hA3, 1'b1, 2'd2, 8'h08);
    send_req(32'h0000102B, 64'hB1, 64'hB2, 64'hB3, 1'b1, 2'd0, 8'h04);
    send_req(32'h0000402B, 64'hC1, 64'hC2, 64'hC3, 1'b1, 2'd1, 8'h10);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_rdy",  req_rdy,  0);
      chk("stall_disp_vld", disp_vld, 1);
      chk("stall_disp_op",  disp_op,  2'd2);
      chk("stall_disp_rs1", disp_rs1, 64'hA1);
      chk("stall_disp_rs3", disp_rs3, 64'hA3);
      step(1);
    end
    disp_rdy = 1'b1;
    step(1);
    wait_for(1, 20, "stall_resp_timeout");
    for (int i = 0; i < 4; i++) begin
      chk("hold_resp_vld",  resp_vld,  1);
      chk("hold_resp_data", resp_data, {48'd0, tag_a, 8'h08});
      chk("hold_req_rdy",   req_rdy,   0);
      step(1);
    end
    resp_rdy = 1'b1;
    step(1);
    chk("full_until_pop", req_rdy, 0);
    wait_for(2, 4, "rdy_after_pop_timeout");
    wait_for(3, 100, "stall_drain_timeout");

    // ---- spurious done in IDLE and in DISP ----
    done_man = 1'b1;
    step(1);
    done_man = 1'b0;
    step(1);
    chk("idle_done_no_disp", disp_vld, 0);
    chk("idle_done_no_resp", resp_vld, 0);
    disp_rdy = 1'b0;
    be_lat   = 4'd6;
    send_req(32'h0000302B, 64'hD1, 64'hD2, 64'hD3, 1'b1, 2'd3, 8'h0C);
    wait_for(0, 5, "spur_disp_timeout");
    done_man = 1'b1;
    step(1);
    chk("disp_done_ignored", disp_vld, 1);
    disp_rdy = 1'b1;
    step(1);
    done_man = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("wait_no_early_resp", resp_vld, 0);
      step(1);
    end
    wait_for(1, 10, "spur_resp_timeout");
    wait_for(3, 50, "spur_drain_timeout");

    // ---- 256 random legal transactions: tag wraps past 255 ----
    for (int t = 0; t < 256; t++) begin
      int          k;
      logic [31:0] ins;
      k        = $urandom_range(0, 3);
      ins      = $urandom();
      ins[6:0] = 7'b0101011;
      ins[14:12] = f3s[k];
      be_lat   = 4'($urandom_range(1, 4));
      send_req(ins, {$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()},
               1'b1, 2'(k), {3'b000, f3s[k], 2'b00});
    end
    wait_for(3, 4000, "wrap_drain_timeout");

    // ---- reset while in WAIT with a request queued behind it ----
    be_lat = 4'd12;
    send_req(32'h0000102B, 64'hE1, 64'hE2, 64'hE3, 1'b1, 2'd0, 8'h04);
    send_req(32'h0000202B, 64'hF1, 64'hF2, 64'hF3, 1'b1, 2'd2, 8'h08);
    step(3);
    rst_n = 1'b0;
    exp_q.delete();
    exp_disp_q.delete();
    tag_m = 8'd0;
    step(1);
    chk("mid_rst_req_rdy",   req_rdy,   0);
    chk("mid_rst_disp_vld",  disp_vld,  0);
    chk("mid_rst_resp_vld",  resp_vld,  0);
    chk("mid_rst_disp_op",   disp_op,   0);
    chk("mid_rst_disp_rs1",  disp_rs1,  0);
    chk("mid_rst_disp_rs2",  disp_rs2,  0);
    chk("mid_rst_disp_rs3",  disp_rs3,  0);
    chk("mid_rst_resp_data", resp_data, 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    done_man = 1'b1;
    step(1);
    done_man = 1'b0;
    step(3);
    chk("post_rst_no_resp", resp_vld, 0);
    chk("post_rst_no_disp", disp_vld, 0);
    be_lat = 4'd2;
    send_req(32'h0000402B, 64'h77, 64'h66, 64'h55, 1'b1, 2'd1, 8'h10);
    wait_for(3, 50, "post_rst_drain_timeout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
